// File: rtl/fifo_to_wide_packer.sv
// Pops narrow words from a FIFO and packs `ratio` of them into one wide word
// held in a single valid/ready output register; flush emits a partial word with a keep mask.
module fifo_to_wide_packer #(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [width-1:0]       fifo_read_data,
  output logic                   fifo_pop,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width*ratio-1:0] out_data,
  output logic [ratio-1:0]       out_keep
);

  localparam int cw = $clog2(ratio);
  localparam logic [cw-1:0] last_lane = cw'(ratio - 1);

  logic [cw-1:0]              cnt_q, cnt_d;
  logic [(ratio-1)*width-1:0] acc_q, acc_d;
  logic [width*ratio-1:0]     out_data_q, out_data_d;
  logic [ratio-1:0]           out_keep_q, out_keep_d;
  logic                       out_valid_q, out_valid_d;

  logic out_free_s;
  logic flush_req_s;
  logic flush_fire_s;
  logic pop_s;

  // Handshake decisions: a pending flush blocks popping even while it cannot fire yet.
  always_comb begin
    out_free_s   = ~out_valid_q | out_ready;
    flush_req_s  = flush & (cnt_q != {cw{1'b0}});
    flush_fire_s = flush_req_s & out_free_s;
    if (rst | flush_req_s | fifo_empty) begin
      pop_s = 1'b0;
    end else begin
      pop_s = (cnt_q != last_lane) | out_free_s;
    end
  end

  assign fifo_pop  = pop_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;

  // Next-state for lane counter, accumulator and output register.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (flush_fire_s) begin
      out_data_d = {(width*ratio){1'b0}};
      for (int i = 0; i < ratio - 1; i++) begin
        if (cw'(i) < cnt_q) begin
          out_data_d[i*width +: width] = acc_q[i*width +: width];
          out_keep_d[i]                = 1'b1;
        end else begin
          out_keep_d[i] = 1'b0;
        end
      end
      out_keep_d[ratio-1] = 1'b0;
      out_valid_d         = 1'b1;
      cnt_d               = {cw{1'b0}};
    end else if (pop_s) begin
      if (cnt_q == last_lane) begin
        // Final lane bypasses the accumulator straight into the top lane.
        out_data_d  = {fifo_read_data, acc_q};
        out_keep_d  = {ratio{1'b1}};
        out_valid_d = 1'b1;
        cnt_d       = {cw{1'b0}};
      end else begin
        for (int i = 0; i < ratio - 1; i++) begin
          if (cw'(i) == cnt_q) begin
            acc_d[i*width +: width] = fifo_read_data;
          end else begin
            acc_d[i*width +: width] = acc_q[i*width +: width];
          end
        end
        cnt_d = cnt_q + cw'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= {cw{1'b0}};
      acc_q       <= {((ratio-1)*width){1'b0}};
      out_data_q  <= {(width*ratio){1'b0}};
      out_keep_q  <= {ratio{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
